// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs_pkg
// Purpose  : Shared PRBS4 constants, tap helper and checker state encoding.
// Revision : 1.0  initial release
// ============================================================================
package prbs_pkg;

  localparam int PRBS_W = 4;
  localparam int TAP_A  = 3;
  localparam int TAP_B  = 2;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_t;

  function automatic logic prbs_next_bit(input logic [PRBS_W-1:0] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs4_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : prbs4_checker_if
// Purpose  : Serial bit input and lock/error status bundle for prbs4_checker.
// Revision : 1.0  initial release
// ============================================================================
interface prbs4_checker_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_bit;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_bit, clr_cnt,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  in_valid, in_bit, clr_cnt,
    output locked, err_pulse, err_count
  );
endinterface
`default_nettype wire

// File: rtl/prbs4_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs4_checker
// Purpose  : Self-synchronising PRBS4 checker with lock, error pulse and count.
// Revision : 1.0  initial release
// ============================================================================
module prbs4_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT   = 8,
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 8,
  parameter int CNT_W      = 16
) (
  input wire logic        clk,
  input wire logic        rst,
  prbs4_checker_if.slave  bus
);

  localparam logic [7:0]       c_lock_cnt   = 8'(LOCK_CNT);
  localparam logic [15:0]      c_win_last   = 16'(WINDOW - 1);
  localparam logic [15:0]      c_err_thresh = 16'(ERR_THRESH);
  localparam logic [CNT_W-1:0] c_cnt_max    = '1;
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

  prbs_state_t       r_state;
  logic [PRBS_W-1:0] r_shift;
  logic [1:0]        r_fill_cnt;
  logic [7:0]        r_match_cnt;
  logic [15:0]       r_win_cnt;
  logic [15:0]       r_win_err;
  logic              r_locked;
  logic              r_err_pulse;
  logic [CNT_W-1:0]  r_err_count;

  logic              w_pred;
  logic              w_err;
  logic [15:0]       w_win_err_nxt;

  assign w_pred        = prbs_next_bit(r_shift);
  assign w_err         = bus.in_valid && (r_state == LOCKED) && (bus.in_bit != w_pred);
  assign w_win_err_nxt = r_win_err + 16'(w_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FILL;
      r_shift     <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_err;

      if (bus.clr_cnt) begin
        r_err_count <= w_err ? c_cnt_one : '0;
      end else if (w_err && (r_err_count != c_cnt_max)) begin
        r_err_count <= r_err_count + c_cnt_one;
      end

      if (bus.in_valid) begin
        case (r_state)
          FILL: begin
            r_shift    <= {r_shift[PRBS_W-2:0], bus.in_bit};
            r_fill_cnt <= r_fill_cnt + 2'd1;
            if (r_fill_cnt == 2'd3) begin
              r_state     <= VERIFY;
              r_match_cnt <= '0;
            end
          end

          VERIFY: begin
            r_shift <= {r_shift[PRBS_W-2:0], bus.in_bit};
            // All-zero history is the LFSR lock-up state and must never count
            if ((bus.in_bit == w_pred) && (r_shift != '0)) begin
              r_match_cnt <= r_match_cnt + 8'd1;
              if ((r_match_cnt + 8'd1) == c_lock_cnt) begin
                r_state   <= LOCKED;
                r_locked  <= 1'b1;
                r_win_cnt <= '0;
                r_win_err <= '0;
              end
            end else begin
              r_match_cnt <= '0;
            end
          end

          LOCKED: begin
            // Free-run on the prediction so one flipped bit is counted once
            r_shift <= {r_shift[PRBS_W-2:0], w_pred};
            if (w_err && (w_win_err_nxt == c_err_thresh)) begin
              r_state    <= FILL;
              r_fill_cnt <= '0;
              r_locked   <= 1'b0;
            end else if (r_win_cnt == c_win_last) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + 16'd1;
              r_win_err <= w_win_err_nxt;
            end
          end

          default: begin
            r_state  <= FILL;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_err_pulse;
  assign bus.err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_prbs4_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs4_checker
// Purpose  : Directed self-checking bench for prbs4_checker.
// Revision : 1.0  initial release
// ============================================================================
module tb_prbs4_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  prbs4_checker_if #(.CNT_W(16)) ia ();
  prbs4_checker_if #(.CNT_W(2))  ib ();

  prbs4_checker #(.LOCK_CNT(4), .WINDOW(16), .ERR_THRESH(3), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ia.slave)
  );

  prbs4_checker #(.LOCK_CNT(4), .WINDOW(64), .ERR_THRESH(8), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ib.slave)
  );

  // Generator output seeded with 4'hf
  bit ref_bits [0:14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                          1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  int total = 0;
  int bad   = 0;
  int idx_a = 0;
  int idx_b = 0;

  task automatic drive_a(input logic v, input logic b, input logic clr);
    ia.in_valid = v;
    ia.in_bit   = b;
    ia.clr_cnt  = clr;
    @(negedge clk);
    ia.in_valid = 1'b0;
    ia.clr_cnt  = 1'b0;
  endtask

  task automatic send_a(input logic flip);
    drive_a(1'b1, ref_bits[idx_a] ^ flip, 1'b0);
    idx_a = (idx_a + 1) % 15;
  endtask

  task automatic send_b(input logic v, input logic flip, input logic clr);
    ib.in_valid = v;
    ib.in_bit   = v ? (ref_bits[idx_b] ^ flip) : 1'($urandom_range(0, 1));
    ib.clr_cnt  = clr;
    @(negedge clk);
    if (v) idx_b = (idx_b + 1) % 15;
    ib.in_valid = 1'b0;
    ib.clr_cnt  = 1'b0;
  endtask

  task automatic reset_a();
    rst_a       = 1'b1;
    ia.in_valid = 1'b1;
    ia.in_bit   = 1'b1;
    ia.clr_cnt  = 1'b1;
    @(negedge clk);
    rst_a       = 1'b0;
    ia.in_valid = 1'b0;
    ia.clr_cnt  = 1'b0;
    idx_a       = 0;
  endtask

  task automatic reset_b();
    rst_b       = 1'b1;
    ib.in_valid = 1'b0;
    ib.clr_cnt  = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    idx_b = 0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    ia.in_valid = 1'b1; ia.in_bit = 1'b0; ia.clr_cnt = 1'b0;
    ib.in_valid = 1'b1; ib.in_bit = 1'b0; ib.clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ia.locked !== 1'b0)     begin bad++; $display("FAIL rst_locked_a got=%b want=0", ia.locked); end
    total++; if (ia.err_pulse !== 1'b0)  begin bad++; $display("FAIL rst_pulse_a got=%b want=0", ia.err_pulse); end
    total++; if (ia.err_count !== 16'd0) begin bad++; $display("FAIL rst_count_a got=%0d want=0", ia.err_count); end
    total++; if (ib.locked !== 1'b0)     begin bad++; $display("FAIL rst_locked_b got=%b want=0", ib.locked); end
    total++; if (ib.err_pulse !== 1'b0)  begin bad++; $display("FAIL rst_pulse_b got=%b want=0", ib.err_pulse); end
    total++; if (ib.err_count !== 2'd0)  begin bad++; $display("FAIL rst_count_b got=%0d want=0", ib.err_count); end
    rst_a = 1'b0;
    rst_b = 1'b0;
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
    idx_a = 0;
    idx_b = 0;
  endtask

  task automatic test_clean_lock();
    reset_a();
    repeat (7) send_a(1'b0);
    total++; if (ia.locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%b want=0", ia.locked); end
    send_a(1'b0);
    total++; if (ia.locked !== 1'b1) begin bad++; $display("FAIL lock_at_8 got=%b want=1", ia.locked); end
    for (int i = 0; i < 92; i++) begin
      send_a(1'b0);
      total++;
      if (ia.locked !== 1'b1 || ia.err_pulse !== 1'b0) begin
        bad++; $display("FAIL clean_run bit=%0d locked=%b pulse=%b want 1/0", i, ia.locked, ia.err_pulse);
      end
    end
    total++; if (ia.err_count !== 16'd0) begin bad++; $display("FAIL clean_count got=%0d want=0", ia.err_count); end
  endtask

  task automatic test_single_error();
    send_a(1'b1);
    total++; if (ia.err_pulse !== 1'b1)  begin bad++; $display("FAIL single_pulse got=%b want=1", ia.err_pulse); end
    total++; if (ia.err_count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d want=1", ia.err_count); end
    total++; if (ia.locked !== 1'b1)     begin bad++; $display("FAIL single_locked got=%b want=1", ia.locked); end
    for (int i = 0; i < 20; i++) begin
      send_a(1'b0);
      total++;
      if (ia.err_pulse !== 1'b0) begin bad++; $display("FAIL single_after bit=%0d pulse=%b want=0", i, ia.err_pulse); end
    end
    total++; if (ia.err_count !== 16'd1) begin bad++; $display("FAIL single_final got=%0d want=1", ia.err_count); end
  endtask

  task automatic test_loss_of_lock();
    reset_a();
    repeat (8) send_a(1'b0);
    send_a(1'b1);
    repeat (2) send_a(1'b0);
    send_a(1'b1);
    total++; if (ia.locked !== 1'b1)     begin bad++; $display("FAIL lol_hold got=%b want=1", ia.locked); end
    repeat (2) send_a(1'b0);
    send_a(1'b1);
    total++; if (ia.err_count !== 16'd3) begin bad++; $display("FAIL lol_count got=%0d want=3", ia.err_count); end
    total++; if (ia.err_pulse !== 1'b1)  begin bad++; $display("FAIL lol_pulse got=%b want=1", ia.err_pulse); end
    total++; if (ia.locked !== 1'b0)     begin bad++; $display("FAIL lol_drop got=%b want=0", ia.locked); end
    repeat (7) send_a(1'b0);
    total++; if (ia.locked !== 1'b0)     begin bad++; $display("FAIL relock_early got=%b want=0", ia.locked); end
    send_a(1'b0);
    total++; if (ia.locked !== 1'b1)     begin bad++; $display("FAIL relock got=%b want=1", ia.locked); end
    total++; if (ia.err_count !== 16'd3) begin bad++; $display("FAIL relock_count got=%0d want=3", ia.err_count); end
  endtask

  task automatic test_zero_stream();
    reset_a();
    for (int i = 0; i < 200; i++) begin
      drive_a(1'b1, 1'b0, 1'b0);
      total++;
      if (ia.locked !== 1'b0 || ia.err_pulse !== 1'b0) begin
        bad++; $display("FAIL zero_run bit=%0d locked=%b pulse=%b want 0/0", i, ia.locked, ia.err_pulse);
      end
    end
    total++; if (ia.err_count !== 16'd0) begin bad++; $display("FAIL zero_count got=%0d want=0", ia.err_count); end
  endtask

  task automatic test_gaps_and_clear();
    int   nvalid;
    int   cycles;
    logic v;
    logic exp_lock;
    logic [1:0] exp_cnt [0:3];
    reset_b();
    nvalid = 0;
    cycles = 0;
    while (nvalid < 8 && cycles < 300) begin
      v = 1'($urandom_range(0, 1));
      send_b(v, 1'b0, 1'b0);
      if (v) nvalid++;
      cycles++;
      exp_lock = (nvalid >= 8);
      total++;
      if (ib.locked !== exp_lock) begin
        bad++; $display("FAIL gap_lock valid=%0d got=%b want=%b", nvalid, ib.locked, exp_lock);
      end
    end
    total++; if (nvalid < 8) begin bad++; $display("FAIL gap_timeout valid=%0d want=8", nvalid); end

    send_b(1'b0, 1'b0, 1'b0);
    send_b(1'b1, 1'b1, 1'b0);
    total++; if (ib.err_count !== 2'd1) begin bad++; $display("FAIL gap_err1 got=%0d want=1", ib.err_count); end
    send_b(1'b0, 1'b0, 1'b0);
    total++; if (ib.err_pulse !== 1'b0) begin bad++; $display("FAIL gap_idle_pulse got=%b want=0", ib.err_pulse); end
    send_b(1'b1, 1'b1, 1'b0);
    total++; if (ib.err_count !== 2'd2) begin bad++; $display("FAIL gap_err2 got=%0d want=2", ib.err_count); end
    send_b(1'b1, 1'b0, 1'b0);
    send_b(1'b1, 1'b1, 1'b1);
    total++; if (ib.err_count !== 2'd1) begin bad++; $display("FAIL clr_with_err got=%0d want=1", ib.err_count); end
    total++; if (ib.err_pulse !== 1'b1) begin bad++; $display("FAIL clr_with_err_pulse got=%b want=1", ib.err_pulse); end
    send_b(1'b0, 1'b0, 1'b1);
    total++; if (ib.err_count !== 2'd0) begin bad++; $display("FAIL clr_alone got=%0d want=0", ib.err_count); end

    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 4; i++) begin
      send_b(1'b0, 1'b0, 1'b0);
      send_b(1'b1, 1'b0, 1'b0);
      send_b(1'b1, 1'b1, 1'b0);
      total++;
      if (ib.err_count !== exp_cnt[i] || ib.err_pulse !== 1'b1) begin
        bad++; $display("FAIL sat_count step=%0d got=%0d/%b want=%0d/1", i, ib.err_count, ib.err_pulse, exp_cnt[i]);
      end
    end
    total++; if (ib.locked !== 1'b1) begin bad++; $display("FAIL sat_locked got=%b want=1", ib.locked); end
  endtask

  task automatic test_reset_mid_lock();
    reset_a();
    repeat (8) send_a(1'b0);
    for (int i = 0; i < 5; i++) begin
      send_a(1'b1);
      repeat (7) send_a(1'b0);
    end
    total++; if (ia.err_count !== 16'd5) begin bad++; $display("FAIL mid_count got=%0d want=5", ia.err_count); end
    total++; if (ia.locked !== 1'b1)     begin bad++; $display("FAIL mid_locked got=%b want=1", ia.locked); end
    reset_a();
    total++; if (ia.locked !== 1'b0)     begin bad++; $display("FAIL mid_rst_locked got=%b want=0", ia.locked); end
    total++; if (ia.err_count !== 16'd0) begin bad++; $display("FAIL mid_rst_count got=%0d want=0", ia.err_count); end
    total++; if (ia.err_pulse !== 1'b0)  begin bad++; $display("FAIL mid_rst_pulse got=%b want=0", ia.err_pulse); end
    repeat (7) send_a(1'b0);
    total++; if (ia.locked !== 1'b0)     begin bad++; $display("FAIL mid_relock_early got=%b want=0", ia.locked); end
    send_a(1'b0);
    total++; if (ia.locked !== 1'b1)     begin bad++; $display("FAIL mid_relock got=%b want=1", ia.locked); end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ia.in_valid = 1'b0; ia.in_bit = 1'b0; ia.clr_cnt = 1'b0;
    ib.in_valid = 1'b0; ib.in_bit = 1'b0; ib.clr_cnt = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_zero_stream();
    test_gaps_and_clear();
    test_reset_mid_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prbs4_checker.md
# prbs4_checker

Serial pattern checker for the 4-bit maximal-length PRBS used in our generator blocks: next bit = s[3]^s[2], shifted in at s[0], period 15. It self-synchronises to an incoming bit stream and declares lock. While locked it predicts every bit, flags mismatches, and counts them. It sits at the receive end of any link or loopback driven by the PRBS4 generator and supplies lock and error status to test and BIST logic.

## Interface
- LOCK_CNT, 8: consecutive correct predictions needed, after fill, to declare lock (1..255)
- WINDOW, 64: valid-bit window length used for loss-of-lock detection (2..65535)
- ERR_THRESH, 8: errors within one window that force loss of lock (1..WINDOW)
- CNT_W, 16: width of the error counter
- clk  in  1  single clock; everything is registered on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_bit is sampled only when this is high
- in_bit  in  1  received serial PRBS bit
- clr_cnt  in  1  one-cycle pulse that clears err_count
- locked  out  1  checker is in LOCKED
- err_pulse  out  1  one-cycle flag for a mispredicted bit while locked
- err_count  out  CNT_W  saturating count of errors while locked

## Operation
- Internal register r[3:0] holds the last 4 bits, with r[0] newest. Prediction p = r[3]^r[2].
- FSM states: FILL, VERIFY, LOCKED. Cycles with in_valid=0 change no state, counter, or register.
- FILL: r <= {r[2:0], in_bit}; fill_cnt increments. After the 4th valid bit, go to VERIFY with match_cnt=0.
- VERIFY: r <= {r[2:0], in_bit}, so the received bit is shifted in.
  - If in_bit==p and r!=4'h0, match_cnt increments.
  - Otherwise match_cnt <= 0.
  - The all-zero r is the lock-up state and never counts as a match, so a constant-zero stream never locks.
  - When match_cnt reaches LOCK_CNT, go to LOCKED with win_cnt=0 and win_err=0.
- LOCKED: r <= {r[2:0], p}, so the checker free-runs and a single bit error is counted once, not multiplied.
  - Mismatch (in_bit!=p): err_pulse=1 next cycle, err_count increments (saturating at all-ones), win_err increments.
  - win_cnt increments on every valid bit.
- Loss of lock: if the current bit brings win_err to ERR_THRESH, go to FILL, with fill_cnt=0 and locked=0 next cycle. This takes priority over the window end.
- Window end: on the WINDOW-th valid bit, after evaluating that bit's error, win_cnt and win_err reset to 0.
- clr_cnt: err_count <= 0. If an error occurs in the same cycle, err_count <= 1.
- rst (any time, including mid-lock):
  - FSM state goes to FILL.
  - r, fill_cnt, match_cnt, win_cnt and win_err go to 0.
  - locked, err_pulse and err_count go to 0.
  - rst overrides all other inputs.

## Timing
- All outputs are registered. Reset values: locked=0, err_pulse=0, err_count=0.
- locked rises the cycle after the valid bit that makes match_cnt==LOCK_CNT.
- Minimum time to lock: 4+LOCK_CNT valid bits.
- err_pulse and the err_count update appear the cycle after the errored bit's valid cycle. No error is reported outside LOCKED.
- locked falls the cycle after the threshold-reaching bit. err_pulse is still reported for that bit.
- Gaps in in_valid stretch all latencies, with no other effect.

## Structure
- Package prbs_pkg holds:
  - PRBS_W=4 and tap indices TAP_A=3, TAP_B=2.
  - Function prbs_next_bit(logic [3:0]).
  - State enum {FILL, VERIFY, LOCKED}.
- The generator and checker share this package.
- No sub-module. This is a single FSM plus counters, roughly 150-200 lines.

## Test plan
Reference stream: the generator seeded with 4'hf emits 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1 and then repeats.

1. Clean lock: LOCK_CNT=4, rst then the reference stream with in_valid=1 every cycle. locked=1 in the cycle after the 8th bit. err_pulse stays 0 and err_count stays 0 over 100 bits.
2. Single error: after lock, invert one bit. Exactly one err_pulse, err_count=1, locked stays 1, and the following bits raise no further errors.
3. Loss of lock: WINDOW=16, ERR_THRESH=3, invert 3 bits within 16 bits. err_count=3, then locked=0 one cycle after the 3rd error. Relock follows 8 bits later.
4. Zero stream: feed 200 zero bits. locked stays 0 and err_count stays 0.
5. Gaps and clear: random in_valid duty of 50%. Locks after 8 valid bits. clr_cnt pulsed in the same cycle as an error gives err_count=1. err_count saturates at 2^CNT_W-1 with CNT_W=2.
6. Reset mid-lock: assert rst while locked with err_count=5. Next cycle locked=0, err_count=0, and the full relock sequence follows.
